mu0_demux16: RTL and testbench

Buffered 1-to-2 demultiplexer for the MU0 16-bit datapath: the distributing counterpart to the 2-to-1 source mux. A single 16-bit producer steers each word to one of two consumers (channel A or channel B) under a select bit. Each channel has its own 2-entry FIFO and valid/ready handshake, so one stalled consumer never blocks words destined for the other once they are buffered.

---
 rtl/mu0_demux16.sv | 123 ++++++++++++
 tb/tb_mu0_demux16.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mu0_demux16.sv
// mu0_demux16: buffered 1-to-2 demultiplexer for the MU0 16-bit datapath.
// Each destination channel owns a 2-entry FIFO with its own valid/ready
// handshake, so a stalled consumer never blocks words already buffered for
// the other channel.

module mu0_demux16_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot0_q, slot1_q;
    logic             wptr_q, rptr_q;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;
    assign pop     = valid_o && ready_i;

    // Head word is forced to zero when the channel is empty.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            data_o = rptr_q ? slot1_q : slot0_q;
        end
    end

    // Occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; push is only ever asserted when not full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                if (wptr_q) begin
                    slot1_q <= wdata_i;
                end else begin
                    slot0_q <= wdata_i;
                end
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

module mu0_demux16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             s_i,
    input  logic             d_valid_i,
    output logic             d_ready_o,
    output logic [WIDTH-1:0] a_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic [WIDTH-1:0] b_o,
    output logic             b_valid_o,
    input  logic             b_ready_i,
    output logic [1:0]       a_count_o,
    output logic [1:0]       b_count_o
);

    logic push_a, push_b;

    // Ready looks only at the selected channel's registered count, so a pop
    // in the same cycle never opens a full channel (no pass-through).
    always_comb begin
        d_ready_o = s_i ? (b_count_o != 2'd2) : (a_count_o != 2'd2);
        push_a    = d_valid_i && d_ready_o && !s_i;
        push_b    = d_valid_i && d_ready_o &&  s_i;
    end

    mu0_demux16_chan #(.WIDTH(WIDTH)) u_chan_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_a),
        .wdata_i (d_i),
        .ready_i (a_ready_i),
        .data_o  (a_o),
        .valid_o (a_valid_o),
        .count_o (a_count_o)
    );

    mu0_demux16_chan #(.WIDTH(WIDTH)) u_chan_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_b),
        .wdata_i (d_i),
        .ready_i (b_ready_i),
        .data_o  (b_o),
        .valid_o (b_valid_o),
        .count_o (b_count_o)
    );

endmodule

// File: tb/tb_mu0_demux16.sv
module tb_mu0_demux16;

    logic        clk_i = 1'b1;
    logic        rst_i;
    logic [15:0] d_i;
    logic        s_i;
    logic        d_valid_i;
    logic        d_ready_o;
    logic [15:0] a_o;
    logic        a_valid_o;
    logic        a_ready_i;
    logic [15:0] b_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [1:0]  a_count_o;
    logic [1:0]  b_count_o;

    int npass = 0;
    int ntot  = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    logic        prev_stall = 1'b0;
    logic        prev_s;
    logic [15:0] prev_d;

    always #5 clk_i = ~clk_i;

    mu0_demux16 dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .d_i       (d_i),
        .s_i       (s_i),
        .d_valid_i (d_valid_i),
        .d_ready_o (d_ready_o),
        .a_o       (a_o),
        .a_valid_o (a_valid_o),
        .a_ready_i (a_ready_i),
        .b_o       (b_o),
        .b_valid_o (b_valid_o),
        .b_ready_i (b_ready_i),
        .a_count_o (a_count_o),
        .b_count_o (b_count_o)
    );

    typedef struct packed {
        logic        s;
        logic [15:0] d;
        logic        dv;
        logic        ar;
        logic        br;
        logic        exp_dr;
        logic [1:0]  exp_ac;
        logic [1:0]  exp_bc;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_state(input string tag);
        check({tag, " a_count"}, int'(a_count_o), qa.size());
        check({tag, " b_count"}, int'(b_count_o), qb.size());
        check({tag, " a_valid"}, int'(a_valid_o), int'(qa.size() != 0));
        check({tag, " b_valid"}, int'(b_valid_o), int'(qb.size() != 0));
        check({tag, " a_head"}, int'(a_o), (qa.size() != 0) ? int'(qa[0]) : 0);
        check({tag, " b_head"}, int'(b_o), (qb.size() != 0) ? int'(qb[0]) : 0);
    endtask

    // Called at a falling edge: drive, check against the queue model, update
    // the model with the handshakes that occur at the next rising edge.
    task automatic step(input logic s, input logic [15:0] d, input logic dv,
                        input logic ar, input logic br, output logic dr_seen);
        bit exp_dr, push, pop_a, pop_b;
        s_i = s; d_i = d; d_valid_i = dv; a_ready_i = ar; b_ready_i = br;
        #1;
        if (prev_stall && dv) begin
            check("protocol s_hold", int'(s), int'(prev_s));
            check("protocol d_hold", int'(d), int'(prev_d));
        end
        exp_dr = s ? (qb.size() != 2) : (qa.size() != 2);
        check("d_ready", int'(d_ready_o), int'(exp_dr));
        check_state("pre");
        dr_seen = d_ready_o;
        push  = dv && exp_dr;
        pop_a = ar && (qa.size() != 0);
        pop_b = br && (qb.size() != 0);
        if (pop_a) begin
            check("pop_a word", int'(a_o), int'(qa[0]));
            void'(qa.pop_front());
        end
        if (pop_b) begin
            check("pop_b word", int'(b_o), int'(qb[0]));
            void'(qb.pop_front());
        end
        if (push) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        prev_stall = dv && !exp_dr;
        prev_s = s;
        prev_d = d;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        logic dr;
        // s, d, dv, ar, br, exp d_ready before edge, exp a/b counts after edge
        tbl[0]  = '{1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        tbl[1]  = '{1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
        tbl[2]  = '{1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        tbl[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[9]  = '{1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[11] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1};
        tbl[12] = '{1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2};
        tbl[13] = '{1'b0, 16'h0A0A, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2};
        tbl[15] = '{1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2};
        tbl[16] = '{1'b0, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2};
        tbl[17] = '{1'b0, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1};
        tbl[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};

        rst_i = 1'b1; d_i = '0; s_i = 1'b0; d_valid_i = 1'b0;
        a_ready_i = 1'b0; b_ready_i = 1'b0;
        #1;
        check("reset d_ready", int'(d_ready_o), 1);
        check_state("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].dv, tbl[i].ar, tbl[i].br, dr);
            check($sformatf("tbl%0d d_ready", i), int'(dr), int'(tbl[i].exp_dr));
            check($sformatf("tbl%0d a_count", i), int'(a_count_o), int'(tbl[i].exp_ac));
            check($sformatf("tbl%0d b_count", i), int'(b_count_o), int'(tbl[i].exp_bc));
        end

        // Simultaneous push and pop with pointer wrap: 3333 then 0..9 in order.
        step(1'b0, 16'h3333, 1'b1, 1'b0, 1'b0, dr);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'(i), 1'b1, 1'b1, 1'b0, dr);
            check("pushpop a_count", int'(a_count_o), 1);
            check("pushpop head", int'(a_o), (i == 0) ? 16'h0000 + i : i);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, dr);
        check("pushpop drained", int'(a_count_o), 0);

        // Streaming to B with consumer always ready.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'hB000 + 16'(i), 1'b1, 1'b0, 1'b1, dr);
            check("stream b_count", int'(b_count_o), 1);
        end
        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, dr);

        // Asynchronous reset mid-cycle with words in both channels.
        step(1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, dr);
        step(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b0, dr);
        step(1'b1, 16'hBBBC, 1'b1, 1'b0, 1'b0, dr);
        s_i = 1'b1; d_valid_i = 1'b0; a_ready_i = 1'b0; b_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        prev_stall = 1'b0;
        check("async rst d_ready", int'(d_ready_o), 1);
        check_state("async rst");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        step(1'b0, 16'h4444, 1'b1, 1'b0, 1'b0, dr);
        check("post rst head", int'(a_o), 16'h4444);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, dr);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
